// File: rtl/mem_access_stage.sv
// mem_access_stage: Y86-64 memory stage.
// Takes execute results, performs the data-memory read/write over a req/ack
// port, and presents registered writeback fields with a one-cycle w_valid.
// Build option: MEM_TIMEOUT_EN adds a MEM_WAIT watchdog of TIMEOUT cycles.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   e_*                execute-stage handshake and result fields
//   mem_*              data-memory request/ack port
//   w_*                registered writeback fields, w_valid pulses per retire
//   stat               sticky stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
module mem_access_stage #(
    parameter int unsigned N         = 64,
    parameter int unsigned MEM_BYTES = 8192
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 16
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         e_valid,
    output logic         e_ready,
    input  logic [3:0]   e_icode,
    input  logic [N-1:0] e_valE,
    input  logic [N-1:0] e_valA,
    input  logic [N-1:0] e_valP,
    input  logic [3:0]   e_dstE,
    input  logic [3:0]   e_dstM,
    input  logic         e_cnd,
    input  logic [2:0]   e_stat,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         w_valid,
    output logic [3:0]   w_icode,
    output logic [N-1:0] w_valE,
    output logic [N-1:0] w_valM,
    output logic [3:0]   w_dstE,
    output logic [3:0]   w_dstM,
    output logic [2:0]   stat
);

    typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_HALTED} state_t;

    localparam logic [3:0]   REG_NONE = 4'hF;
    localparam logic [2:0]   STAT_AOK = 3'd1;
    localparam logic [2:0]   STAT_ADR = 3'd3;
    localparam logic [N-1:0] ADDR_MAX = N'(MEM_BYTES - 8);

    state_t       r_state, w_state_nxt;
    logic         r_mem_req, w_mem_req_nxt;
    logic         r_mem_we, w_mem_we_nxt;
    logic [N-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [N-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic         r_w_valid, w_valid_nxt;
    logic [3:0]   r_w_icode, w_icode_nxt;
    logic [N-1:0] r_w_valE, w_valE_nxt;
    logic [N-1:0] r_w_valM, w_valM_nxt;
    logic [3:0]   r_w_dstE, w_dstE_nxt;
    logic [3:0]   r_w_dstM, w_dstM_nxt;
    logic [2:0]   r_stat, w_stat_nxt;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

    // Access decode: direction, address and write data per icode
    logic         w_is_read, w_is_write;
    logic [N-1:0] w_acc_addr, w_acc_wdata;

    always_comb begin
        w_is_read   = 1'b0;
        w_is_write  = 1'b0;
        w_acc_addr  = e_valE;
        w_acc_wdata = e_valA;
        case (e_icode)
            4'd4:        w_is_write = 1'b1;
            4'd5:        w_is_read  = 1'b1;
            4'd8: begin
                w_is_write  = 1'b1;
                w_acc_wdata = e_valP;
            end
            4'd10:       w_is_write = 1'b1;
            4'd9, 4'd11: begin
                w_is_read  = 1'b1;
                w_acc_addr = e_valA;
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_valid_nxt     = 1'b0;
        w_icode_nxt     = r_w_icode;
        w_valE_nxt      = r_w_valE;
        w_valM_nxt      = r_w_valM;
        w_dstE_nxt      = r_w_dstE;
        w_dstM_nxt      = r_w_dstM;
        w_stat_nxt      = r_stat;
`ifdef MEM_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (e_valid) begin
                    w_icode_nxt = e_icode;
                    w_valE_nxt  = e_valE;
                    w_valM_nxt  = '0;
                    // Untaken cmov must not write its destination
                    w_dstE_nxt  = (e_icode == 4'd2 && !e_cnd) ? REG_NONE : e_dstE;
                    w_dstM_nxt  = e_dstM;
                    if (e_stat != STAT_AOK) begin
                        w_valid_nxt = 1'b1;
                        w_stat_nxt  = e_stat;
                        w_state_nxt = S_HALTED;
                    end else if (w_is_read || w_is_write) begin
                        if (w_acc_addr > ADDR_MAX) begin
                            w_valid_nxt = 1'b1;
                            w_stat_nxt  = STAT_ADR;
                            w_state_nxt = S_HALTED;
                        end else begin
                            w_mem_req_nxt   = 1'b1;
                            w_mem_we_nxt    = w_is_write;
                            w_mem_addr_nxt  = w_acc_addr;
                            w_mem_wdata_nxt = w_acc_wdata;
                            w_state_nxt     = S_MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
                            w_cnt_nxt       = '0;
`endif
                        end
                    end else begin
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            S_MEM_WAIT: begin
                // An ack on the limit cycle still completes normally
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_valM_nxt    = r_mem_we ? '0 : mem_rdata;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_mem_req_nxt = 1'b0;
                    w_valM_nxt    = '0;
                    w_valid_nxt   = 1'b1;
                    w_stat_nxt    = STAT_ADR;
                    w_state_nxt   = S_HALTED;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_HALTED: ;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_w_valid   <= 1'b0;
            r_w_icode   <= '0;
            r_w_valE    <= '0;
            r_w_valM    <= '0;
            r_w_dstE    <= REG_NONE;
            r_w_dstM    <= REG_NONE;
            r_stat      <= STAT_AOK;
`ifdef MEM_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_w_valid   <= w_valid_nxt;
            r_w_icode   <= w_icode_nxt;
            r_w_valE    <= w_valE_nxt;
            r_w_valM    <= w_valM_nxt;
            r_w_dstE    <= w_dstE_nxt;
            r_w_dstM    <= w_dstM_nxt;
            r_stat      <= w_stat_nxt;
`ifdef MEM_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

    assign e_ready   = (r_state == S_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign w_valid   = r_w_valid;
    assign w_icode   = r_w_icode;
    assign w_valE    = r_w_valE;
    assign w_valM    = r_w_valM;
    assign w_dstE    = r_w_dstE;
    assign w_dstM    = r_w_dstM;
    assign stat      = r_stat;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed transactions, expected writeback
// records queued at issue and checked by a monitor on each w_valid pulse.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid, e_ready;
    logic [3:0]  e_icode, e_dstE, e_dstM;
    logic [63:0] e_valE, e_valA, e_valP;
    logic        e_cnd;
    logic [2:0]  e_stat;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        w_valid;
    logic [3:0]  w_icode, w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;
    logic [2:0]  stat;

    mem_access_stage dut (
        .clk(clk), .reset(reset),
        .e_valid(e_valid), .e_ready(e_ready), .e_icode(e_icode),
        .e_valE(e_valE), .e_valA(e_valA), .e_valP(e_valP),
        .e_dstE(e_dstE), .e_dstM(e_dstM), .e_cnd(e_cnd), .e_stat(e_stat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .w_valid(w_valid), .w_icode(w_icode), .w_valE(w_valE), .w_valM(w_valM),
        .w_dstE(w_dstE), .w_dstM(w_dstM), .stat(stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [2:0]  st;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          w_seen = 0;
    int          req_cycles = 0;
    int          ready_bad = 0;
    int          ack_delay = 0;
    logic        stray_ack = 1'b0;
    logic [63:0] rd_val = '0;
    logic        cap_we;
    logic [63:0] cap_addr, cap_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] vm,
                                input logic [3:0] de, input logic [3:0] dm, input logic [2:0] st);
        exp_t e;
        e.icode = ic; e.valE = ve; e.valM = vm; e.dstE = de; e.dstM = dm; e.st = st;
        return e;
    endfunction

    // Monitor: every writeback pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!reset && w_valid) begin
            w_seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_w_valid: got icode %0h, expected no retire", w_icode);
            end else begin
                mon_e = q.pop_front();
                check("w_icode", 64'(w_icode), 64'(mon_e.icode));
                check("w_valE",  w_valE, mon_e.valE);
                check("w_valM",  w_valM, mon_e.valM);
                check("w_dstE",  64'(w_dstE), 64'(mon_e.dstE));
                check("w_dstM",  64'(w_dstM), 64'(mon_e.dstM));
                check("w_stat",  64'(stat), 64'(mon_e.st));
            end
        end
    end

    // Memory responder: acks on the ack_delay-th request cycle, records first-cycle request
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 64'hBAD0_BAD0;
        end else if (mem_req && !reset) begin
            req_cycles++;
            if (req_cycles == 1) begin
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
            end
            if (e_ready) ready_bad++;
            if (ack_delay != 0 && req_cycles == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_val;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [63:0] vp, input logic [3:0] de, input logic [3:0] dm,
                         input logic cnd, input logic [2:0] st, input int dly,
                         input logic [63:0] rd, input exp_t e);
        ack_delay  = dly;
        rd_val     = rd;
        req_cycles = 0;
        ready_bad  = 0;
        @(posedge clk);
        #1;
        e_icode = ic; e_valE = ve; e_valA = va; e_valP = vp;
        e_dstE = de; e_dstM = dm; e_cnd = cnd; e_stat = st; e_valid = 1'b1;
        check("e_ready_at_issue", 64'(e_ready), 64'd1);
        q.push_back(e);
        @(posedge clk);
        #1 e_valid = 1'b0;
    endtask

    // Returns accept-to-w_valid latency in cycles; 0 with a FAIL on expiry
    task automatic wait_w(input int budget, output int lat);
        int base;
        base = w_seen;
        lat  = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            #1;
            if (w_seen != base) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_w_timeout: got no w_valid, expected one within %0d cycles", budget);
        end
    endtask

    // Verify no retire and e_ready stays at rdy for n cycles
    task automatic quiet(input string name, input int n, input logic rdy);
        int base;
        int bad;
        base = w_seen;
        bad  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (e_ready !== rdy) bad++;
        end
        check({name, "_no_w"}, 64'(w_seen - base), 64'd0);
        check({name, "_e_ready"}, 64'(bad), 64'd0);
    endtask

    int lat;

    initial begin
        e_valid = 0; e_icode = 0; e_valE = 0; e_valA = 0; e_valP = 0;
        e_dstE = 4'hF; e_dstM = 4'hF; e_cnd = 0; e_stat = 3'd1;
        mem_ack = 0; mem_rdata = 0;
        do_reset();

        // Reset state
        check("rst_e_ready", 64'(e_ready), 64'd1);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we",  64'(mem_we), 64'd0);
        check("rst_addr",    mem_addr, 64'd0);
        check("rst_wdata",   mem_wdata, 64'd0);
        check("rst_valE",    w_valE, 64'd0);
        check("rst_valM",    w_valM, 64'd0);
        check("rst_dstE",    64'(w_dstE), 64'hF);
        check("rst_dstM",    64'(w_dstM), 64'hF);
        check("rst_icode",   64'(w_icode), 64'd0);
        check("rst_stat",    64'(stat), 64'd1);

        // irmovq: no access, 1-cycle latency
        issue(4'd3, 64'h40, 64'h0, 64'h0, 4'd2, 4'hF, 1'b1, 3'd1, 0, 64'h0,
              mk(4'd3, 64'h40, 64'h0, 4'd2, 4'hF, 3'd1));
        wait_w(20, lat);
        check("irmovq_lat", 64'(lat), 64'd1);
        check("irmovq_no_req", 64'(req_cycles), 64'd0);

        // mrmovq, ack on third request cycle
        issue(4'd5, 64'h100, 64'h55, 64'h0, 4'hF, 4'd4, 1'b1, 3'd1, 3, 64'hDEAD,
              mk(4'd5, 64'h100, 64'hDEAD, 4'hF, 4'd4, 3'd1));
        wait_w(20, lat);
        check("mrmovq_lat", 64'(lat), 64'd4);
        check("mrmovq_req_cycles", 64'(req_cycles), 64'd3);
        check("mrmovq_we", 64'(cap_we), 64'd0);
        check("mrmovq_addr", cap_addr, 64'h100);
        check("mrmovq_ready_low", 64'(ready_bad), 64'd0);

        // pushq: write of valA, immediate ack; read data must not leak into valM
        issue(4'd10, 64'h1F8, 64'h7, 64'h0, 4'd4, 4'hF, 1'b1, 3'd1, 1, 64'h1234,
              mk(4'd10, 64'h1F8, 64'h0, 4'd4, 4'hF, 3'd1));
        wait_w(20, lat);
        check("pushq_lat", 64'(lat), 64'd2);
        check("pushq_we", 64'(cap_we), 64'd1);
        check("pushq_addr", cap_addr, 64'h1F8);
        check("pushq_wdata", cap_wdata, 64'h7);

        // call: writes valP
        issue(4'd8, 64'h200, 64'h99, 64'h33, 4'd4, 4'hF, 1'b1, 3'd1, 2, 64'h0,
              mk(4'd8, 64'h200, 64'h0, 4'd4, 4'hF, 3'd1));
        wait_w(20, lat);
        check("call_lat", 64'(lat), 64'd3);
        check("call_wdata", cap_wdata, 64'h33);
        check("call_we", 64'(cap_we), 64'd1);

        // popq: reads at valA
        issue(4'd11, 64'h308, 64'h300, 64'h0, 4'd4, 4'd3, 1'b1, 3'd1, 1, 64'hBEEF,
              mk(4'd11, 64'h308, 64'hBEEF, 4'd4, 4'd3, 3'd1));
        wait_w(20, lat);
        check("popq_addr", cap_addr, 64'h300);
        check("popq_we", 64'(cap_we), 64'd0);

        // mrmovq at the highest legal address
        issue(4'd5, 64'd8184, 64'h0, 64'h0, 4'hF, 4'd5, 1'b1, 3'd1, 1, 64'h77,
              mk(4'd5, 64'd8184, 64'h77, 4'hF, 4'd5, 3'd1));
        wait_w(20, lat);
        check("edge_addr_req", 64'(req_cycles), 64'd1);
        check("edge_addr", cap_addr, 64'd8184);

        // cmov not taken vs taken
        issue(4'd2, 64'h5, 64'h5, 64'h0, 4'd3, 4'hF, 1'b0, 3'd1, 0, 64'h0,
              mk(4'd2, 64'h5, 64'h0, 4'hF, 4'hF, 3'd1));
        wait_w(20, lat);
        issue(4'd2, 64'h6, 64'h6, 64'h0, 4'd3, 4'hF, 1'b1, 3'd1, 0, 64'h0,
              mk(4'd2, 64'h6, 64'h0, 4'd3, 4'hF, 3'd1));
        wait_w(20, lat);

        // Ack while idle is ignored
        @(posedge clk); #1 stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        quiet("stray_idle", 4, 1'b1);

        // rmmovq past the end of memory
        issue(4'd4, 64'd8190, 64'h1, 64'h0, 4'hF, 4'hF, 1'b1, 3'd1, 1, 64'h0,
              mk(4'd4, 64'd8190, 64'h0, 4'hF, 4'hF, 3'd3));
        wait_w(20, lat);
        check("adr_lat", 64'(lat), 64'd1);
        check("adr_no_req", 64'(req_cycles), 64'd0);
        quiet("adr_halted", 5, 1'b0);
        check("adr_stat_sticky", 64'(stat), 64'd3);

        // halt with upstream HLT status
        do_reset();
        issue(4'd0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 3'd2, 0, 64'h0,
              mk(4'd0, 64'h0, 64'h0, 4'hF, 4'hF, 3'd2));
        wait_w(20, lat);
        quiet("hlt_halted", 5, 1'b0);
        check("hlt_stat_sticky", 64'(stat), 64'd2);

        // Reset in the middle of an access, then a late ack
        do_reset();
        issue(4'd5, 64'h80, 64'h0, 64'h0, 4'hF, 4'd1, 1'b1, 3'd1, 0, 64'h0,
              mk(4'd5, 64'h80, 64'h0, 4'hF, 4'd1, 3'd1));
        repeat (3) @(negedge clk);
        check("midrst_req_before", 64'(mem_req), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        q.delete();
        @(posedge clk); #1;
        check("midrst_req_dropped", 64'(mem_req), 64'd0);
        check("midrst_e_ready", 64'(e_ready), 64'd1);
        reset = 1'b0;
        stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        quiet("late_ack", 4, 1'b1);
        check("late_ack_stat", 64'(stat), 64'd1);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no ack ever arrives
        issue(4'd5, 64'h100, 64'h0, 64'h0, 4'hF, 4'd2, 1'b1, 3'd1, 0, 64'h0,
              mk(4'd5, 64'h100, 64'h0, 4'hF, 4'd2, 3'd3));
        wait_w(40, lat);
        check("timeout_req_cycles", 64'(req_cycles), 64'd16);
        check("timeout_lat", 64'(lat), 64'd17);
        check("timeout_req_low", 64'(mem_req), 64'd0);
        quiet("timeout_halted", 3, 1'b0);
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
